// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D conversion interface: sequencer states,
// SCLK divider landmarks and the ADC command word format.
package a2d_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME1 = 2'd1,
    DEAD   = 2'd2,
    FRAME2 = 2'd3
  } a2d_state_t;

  // Divider value loaded at frame start; 9 clk to the first SCLK fall
  localparam logic [4:0] SCLK_PRESET = 5'b10111;
  // Divider value in the cycle before SCLK rises (MISO capture point)
  localparam logic [4:0] SMPL_PT     = 5'b01111;
  // Divider value in the cycle before SCLK falls (shift point)
  localparam logic [4:0] SHFT_PT     = 5'b11111;
  // Bits per SPI frame
  localparam int         FRAME_BITS  = 16;

  // ADC command: channel address sits in bits [13:11], everything else zero
  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Single 16-bit SPI master frame engine. SCLK idles high, data leaves on
// SCLK falls and MISO is captured on SCLK rises. A start pulse loads the
// outgoing word and presets the divider; done pulses for one cycle once the
// sixteenth bit has been shifted in and SS_n has returned high.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rx
);

  localparam logic [DIV_W-1:0] PRESET   = DIV_W'(SCLK_PRESET);
  localparam logic [DIV_W-1:0] SMPL_LOC = DIV_W'(SMPL_PT);
  localparam logic [DIV_W-1:0] SHFT_LOC = DIV_W'(SHFT_PT);
  localparam logic [4:0]       LAST_CNT = 5'(FRAME_BITS - 1);

  logic             busy;
  logic [DIV_W-1:0] div;
  logic             miso_smpl;
  logic             smpl_seen;
  logic [15:0]      shft;
  logic [4:0]       shft_cnt;
  logic             smpl_now;
  logic             shft_now;
  logic             last_shft;

  // The porch fall (divider's first pass through SHFT_LOC) happens before any
  // bit was captured, so shifting waits until the first sample exists.
  assign smpl_now  = busy && (div == SMPL_LOC);
  assign shft_now  = busy && smpl_seen && (div == SHFT_LOC);
  assign last_shft = shft_now && (shft_cnt == LAST_CNT);

  // Divider runs during a frame and parks on its last count so SCLK ends high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (start) begin
      div <= PRESET;
    end else if (busy && !last_shft) begin
      div <= div + 1'b1;
    end
  end

  // Frame control: busy spans SS_n low, done follows the final shift by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last_shft;
      if (start) begin
        busy <= 1'b1;
      end else if (last_shft) begin
        busy <= 1'b0;
      end
    end
  end

  // MISO capture at the SCLK rise; the first capture arms the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_smpl <= 1'b0;
      smpl_seen <= 1'b0;
    end else if (start) begin
      smpl_seen <= 1'b0;
    end else if (smpl_now) begin
      miso_smpl <= MISO;
      smpl_seen <= 1'b1;
    end
  end

  // Shift register and bit counter, advanced at each post-porch SCLK fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft     <= 16'h0000;
      shft_cnt <= 5'd0;
    end else if (start) begin
      shft     <= cmd;
      shft_cnt <= 5'd0;
    end else if (shft_now) begin
      shft     <= {shft[14:0], miso_smpl};
      shft_cnt <= shft_cnt + 5'd1;
    end
  end

  assign SS_n = ~busy;
  assign SCLK = busy ? div[DIV_W-1] : 1'b1;
  assign MOSI = shft[15];
  assign rx   = shft;

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion interface. A strt_cnv request from IDLE runs two SPI frames
// to the converter separated by a dead time: the first frame addresses the
// channel, the second repeats the address and returns the 12-bit result.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int DIV_W    = 5,
  parameter int DEAD_CYC = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int DC_W = $clog2(DEAD_CYC + 1);

  a2d_state_t      state;
  logic [2:0]      chnnl_q;
  logic [DC_W-1:0] dead_cnt;
  logic            strt_acc;
  logic            dead_done;
  logic            eng_start;
  logic            eng_done;
  logic [15:0]     eng_cmd;
  logic [15:0]     eng_rx;
  logic            unused_rx_hi;

  // Requests outside IDLE are dropped here, so nothing downstream sees them
  assign strt_acc  = (state == IDLE) && strt_cnv;
  assign dead_done = (state == DEAD) && (dead_cnt == DC_W'(DEAD_CYC - 1));
  assign eng_start = strt_acc || dead_done;

  // On the accepting edge the latch is not loaded yet, so take chnnl directly
  assign eng_cmd = cmd_word(strt_acc ? chnnl : chnnl_q);

  // The converter pads the top nibble with zeros; it carries no information
  assign unused_rx_hi = ^eng_rx[15:12];

  spi_mstr16 #(
    .DIV_W (DIV_W)
  ) u_spi (
    .clk   (clk),
    .rst_n (rst_n),
    .start (eng_start),
    .cmd   (eng_cmd),
    .MISO  (MISO),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .done  (eng_done),
    .rx    (eng_rx)
  );

  // Conversion sequencer: address frame, dead time, result frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (strt_cnv)  state <= FRAME1;
        FRAME1:  if (eng_done)  state <= DEAD;
        DEAD:    if (dead_done) state <= FRAME2;
        FRAME2:  if (eng_done)  state <= IDLE;
        default:                state <= IDLE;
      endcase
    end
  end

  // Dead-time counter, cleared whenever the sequencer is elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (state != DEAD) begin
      dead_cnt <= '0;
    end else begin
      dead_cnt <= dead_cnt + 1'b1;
    end
  end

  // Channel latch, loaded only by an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chnnl_q <= 3'd0;
    end else if (strt_acc) begin
      chnnl_q <= chnnl;
    end
  end

  // Result and completion flag: cleared on acceptance, set when frame 2 ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_cmplt <= 1'b0;
      res       <= 12'h000;
    end else if (strt_acc) begin
      cnv_cmplt <= 1'b0;
    end else if ((state == FRAME2) && eng_done) begin
      cnv_cmplt <= 1'b1;
      res       <= eng_rx[11:0];
    end
  end

endmodule
